// File: rtl/audio_pkg.sv
// Shared definitions for the multi-channel DDS tone synthesiser: waveform
// encodings and the helper functions that derive timing and midscale constants.
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_SILENCE = 2'd0,
        MODE_SQUARE  = 2'd1,
        MODE_SAW     = 2'd2,
        MODE_TRI     = 2'd3
    } mode_e;

    // Clock cycles per output sample.
    function automatic int calc_div(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

    // Offset-binary zero level for a given sample width.
    function automatic int calc_mid(input int data_w);
        return 1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/audio_wave_shaper.sv
// Combinational phase-to-sample shaper for one channel: builds a signed
// square/saw/triangle wave from the phase MSBs and scales it by amplitude.
module audio_wave_shaper
    import audio_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic [DATA_W-1:0] p_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] amp_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] sample_o
);

    localparam int MID = calc_mid(DATA_W);

    typedef logic signed [DATA_W:0]     wave_t;
    typedef logic signed [2*DATA_W+1:0] prod_t;

    logic [DATA_W-2:0] tri_t;
    wave_t             w;
    prod_t             prod;
    prod_t             scaled;

    // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
    always_comb begin
        tri_t = p_i[DATA_W-1] ? ~p_i[DATA_W-2:0] : p_i[DATA_W-2:0];
        case (mode_e'(mode_i))
            MODE_SQUARE: w = p_i[DATA_W-1] ? wave_t'(MID - 1) : wave_t'(-MID);
            MODE_SAW:    w = wave_t'({1'b0, p_i}) - wave_t'(MID);
            MODE_TRI:    w = wave_t'({1'b0, tri_t, 1'b0}) - wave_t'(MID);
            default:     w = '0;
        endcase
        // Arithmetic shift floors toward -inf, which keeps the result inside [0, 2*MID-2].
        prod     = prod_t'(w) * prod_t'({1'b0, amp_i});
        scaled   = prod_t'(MID) + (prod >>> DATA_W);
        sample_o = (en_i && (mode_e'(mode_i) != MODE_SILENCE)) ? DATA_W'(scaled) : DATA_W'(MID);
    end

endmodule

// File: rtl/audio_tone_synth.sv
// Multi-channel direct-digital tone synthesiser: per-channel phase accumulators
// stepped at a fixed sample rate, shaped into offset-binary samples for the DAC.
module audio_tone_synth
    import audio_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 20_000,
    parameter int NCH       = 2,
    parameter int PHASE_W   = 24,
    parameter int DATA_W    = 12
) (
    input  logic                    CLOCK,
    input  logic                    RST,
    input  logic [NCH-1:0]          ch_en,
    input  logic [2*NCH-1:0]        ch_mode,
    input  logic [PHASE_W*NCH-1:0]  ch_step,
    input  logic [DATA_W*NCH-1:0]   ch_amp,
    input  logic                    dac_busy,
    output logic [DATA_W*NCH-1:0]   sample_data,
    output logic                    sample_valid,
    output logic [7:0]              overrun_cnt
);

    localparam int                DIV   = calc_div(CLK_HZ, SAMPLE_HZ);
    localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DATA_W-1:0] MID   = DATA_W'(calc_mid(DATA_W));

    logic [CNT_W-1:0]        div_q, div_d;
    logic                    tick;
    logic [PHASE_W-1:0]      phase_q [NCH];
    logic [PHASE_W-1:0]      phase_d [NCH];
    logic [DATA_W*NCH-1:0]   shaped;
    logic [DATA_W*NCH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic [7:0]              ovr_q, ovr_d;

    always_comb begin
        tick  = (div_q == CNT_W'(DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
        for (int i = 0; i < NCH; i++) begin
            phase_d[i] = phase_q[i];
            if (tick) begin
                phase_d[i] = ch_en[i] ? phase_q[i] + ch_step[i*PHASE_W +: PHASE_W] : '0;
            end
        end
    end

    // Shapers see the already-advanced phase so the sample lands one cycle after the tick.
    for (genvar g = 0; g < NCH; g++) begin : g_shaper
        audio_wave_shaper #(.DATA_W(DATA_W)) u_shaper (
            .p_i      (phase_d[g][PHASE_W-1 -: DATA_W]),
            .mode_i   (ch_mode[2*g +: 2]),
            .amp_i    (ch_amp[g*DATA_W +: DATA_W]),
            .en_i     (ch_en[g]),
            .sample_o (shaped[g*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        if (tick) begin
            if (dac_busy) begin
                ovr_d = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;
            end else begin
                data_d  = shaped;
                valid_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            div_q   <= '0;
            // NOTE: the small phase array is reset deliberately; it is state, not bulk storage.
            for (int i = 0; i < NCH; i++) phase_q[i] <= '0;
            data_q  <= {NCH{MID}};
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            div_q   <= div_d;
            for (int i = 0; i < NCH; i++) phase_q[i] <= phase_d[i];
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_audio_tone_synth.sv
// Self-checking bench for audio_tone_synth: hand-computed vector table, directed
// corner sequences and randomized intervals against an arithmetic reference model.
module tb_audio_tone_synth;
    import audio_pkg::*;

    localparam int NCH     = 2;
    localparam int PHASE_W = 24;
    localparam int DATA_W  = 12;
    localparam int DIV     = 10;

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  mode;
        logic [47:0] step;
        logic [23:0] amp;
        logic        busy;
    } cfg_t;

    typedef struct {
        cfg_t        cfg;
        logic [11:0] exp0;
        logic [11:0] exp1;
    } vec_t;

    logic                   CLOCK;
    logic                   RST;
    logic [NCH-1:0]         ch_en;
    logic [2*NCH-1:0]       ch_mode;
    logic [PHASE_W*NCH-1:0] ch_step;
    logic [DATA_W*NCH-1:0]  ch_amp;
    logic                   dac_busy;
    logic [DATA_W*NCH-1:0]  sample_data;
    logic                   sample_valid;
    logic [7:0]             overrun_cnt;

    int          n_tests;
    int          n_fail;
    int unsigned m_phase [NCH];
    int          m_data  [NCH];
    int          m_ovr;

    audio_tone_synth #(
        .CLK_HZ(100), .SAMPLE_HZ(10), .NCH(NCH), .PHASE_W(PHASE_W), .DATA_W(DATA_W)
    ) dut (
        .CLOCK        (CLOCK),
        .RST          (RST),
        .ch_en        (ch_en),
        .ch_mode      (ch_mode),
        .ch_step      (ch_step),
        .ch_amp       (ch_amp),
        .dac_busy     (dac_busy),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .overrun_cnt  (overrun_cnt)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cfg_t mk(input logic [1:0] en, input logic [1:0] m0, input logic [1:0] m1,
                                input logic [23:0] s0, input logic [23:0] s1,
                                input logic [11:0] a0, input logic [11:0] a1, input logic busy);
        cfg_t c;
        c.en   = en;
        c.mode = {m1, m0};
        c.step = {s1, s0};
        c.amp  = {a1, a0};
        c.busy = busy;
        return c;
    endfunction

    // Reference waveform: integer arithmetic straight from the waveform definitions.
    function automatic int shape(input int unsigned phase, input int mode, input int amp, input bit en);
        int p, w, t, prod, q;
        if (!en || mode == 0) return 2048;
        p = int'(phase >> 12);
        case (mode)
            1:       w = (p >= 2048) ? 2047 : -2048;
            2:       w = p - 2048;
            default: begin
                t = (p >= 2048) ? (4095 - p) : p;
                w = 2 * t - 2048;
            end
        endcase
        prod = w * amp;
        q    = prod / 4096;
        if (prod < 0 && (prod % 4096) != 0) q = q - 1;
        return 2048 + q;
    endfunction

    task automatic apply(input cfg_t c);
        ch_en    = c.en;
        ch_mode  = c.mode;
        ch_step  = c.step;
        ch_amp   = c.amp;
        dac_busy = c.busy;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_phase[ch] = 0;
            m_data[ch]  = 2048;
        end
        m_ovr = 0;
    endtask

    task automatic model_tick(input cfg_t c);
        for (int ch = 0; ch < NCH; ch++) begin
            m_phase[ch] = c.en[ch] ? ((m_phase[ch] + int'(c.step[ch*24 +: 24])) & 32'h00FF_FFFF) : 0;
            if (!c.busy) m_data[ch] = shape(m_phase[ch], int'(c.mode[ch*2 +: 2]), int'(c.amp[ch*12 +: 12]), c.en[ch]);
        end
        if (c.busy && m_ovr < 255) m_ovr++;
    endtask

    // One sample interval, starting at a valid (or reset-release) negedge and ending DIV negedges later.
    task automatic run_interval(input cfg_t c, input bit mid, input cfg_t c2);
        logic [23:0] held;
        int          stray;
        int          glitch;
        cfg_t        eff;
        held   = sample_data;
        stray  = 0;
        glitch = 0;
        apply(c);
        for (int i = 1; i <= DIV; i++) begin
            @(negedge CLOCK);
            if (mid && i == 5) apply(c2);
            if (i < DIV) begin
                if (sample_valid) stray++;
                if (sample_data !== held) glitch++;
            end
        end
        eff = mid ? c2 : c;
        model_tick(eff);
        check("stray_valid", 64'(stray), 64'd0);
        check("data_glitch", 64'(glitch), 64'd0);
        check("valid", 64'(sample_valid), 64'(!eff.busy));
        check("data", 64'(sample_data), 64'({12'(m_data[1]), 12'(m_data[0])}));
        check("overrun", 64'(overrun_cnt), 64'(m_ovr));
    endtask

    task automatic reset_release();
        @(negedge CLOCK);
        RST = 1'b0;
        model_reset();
    endtask

    vec_t vecs [6];
    cfg_t c, c2, cb;
    int   bad_range;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b1;
        apply(mk(2'b00, MODE_SILENCE, MODE_SILENCE, 24'h0, 24'h0, 12'h0, 12'h0, 1'b0));
        model_reset();

        // First sample after reset, per vector, computed by hand.
        vecs[0] = '{mk(2'b11, MODE_SQUARE, MODE_SAW, 24'h080000, 24'h100000, 12'hFFF, 12'hFFF, 1'b0), 12'h000, 12'h100};
        vecs[1] = '{mk(2'b11, MODE_SQUARE, MODE_TRI, 24'h900000, 24'h400000, 12'hFFF, 12'hFFF, 1'b0), 12'hFFE, 12'h800};
        vecs[2] = '{mk(2'b11, MODE_TRI, MODE_SAW, 24'hC00000, 24'hFFF000, 12'h800, 12'hFFF, 1'b0), 12'h7FF, 12'hFFE};
        vecs[3] = '{mk(2'b01, MODE_SILENCE, MODE_SQUARE, 24'h123456, 24'h900000, 12'hFFF, 12'hFFF, 1'b0), 12'h800, 12'h800};
        vecs[4] = '{mk(2'b11, MODE_SAW, MODE_SQUARE, 24'h000000, 24'h900000, 12'hFFF, 12'h000, 1'b0), 12'h000, 12'h800};
        vecs[5] = '{mk(2'b11, MODE_SAW, MODE_SQUARE, 24'h800000, 24'h7FFFFF, 12'd1000, 12'd1, 1'b0), 12'h800, 12'h7FF};

        repeat (2) @(negedge CLOCK);
        for (int k = 0; k < 6; k++) begin
            RST = 1'b1;
            apply(vecs[k].cfg);
            reset_release();
            run_interval(vecs[k].cfg, 1'b0, vecs[k].cfg);
            check("vec_ch0", 64'(sample_data[11:0]), 64'(vecs[k].exp0));
            check("vec_ch1", 64'(sample_data[23:12]), 64'(vecs[k].exp1));
        end

        // Reset asserted mid-stream, on a valid cycle with a non-zero overrun count.
        c  = mk(2'b11, MODE_SQUARE, MODE_SAW, 24'h080000, 24'h100000, 12'hFFF, 12'hFFF, 1'b0);
        cb = c;
        cb.busy = 1'b1;
        for (int i = 0; i < 20; i++) run_interval(c, 1'b0, c);
        run_interval(cb, 1'b0, cb);
        run_interval(c, 1'b0, c);
        check("pre_rst_valid", 64'(sample_valid), 64'd1);
        #1 RST = 1'b1;
        #1;
        check("rst_data", 64'(sample_data), 64'h800800);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_overrun", 64'(overrun_cnt), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK);
            check("rst_hold_data", 64'(sample_data), 64'h800800);
            check("rst_hold_valid", 64'(sample_valid), 64'd0);
        end
        reset_release();

        // Square on ch0: samples 1..15 low, 16..31 high, 32 low again; saw on ch1 stays in range.
        bad_range = 0;
        for (int s = 1; s <= 40; s++) begin
            run_interval(c, 1'b0, c);
            if (sample_data[23:12] > 12'd4094) bad_range++;
            if (s == 1)  check("sq_s1", 64'(sample_data[11:0]), 64'h000);
            if (s == 16) check("sq_s16", 64'(sample_data[11:0]), 64'hFFE);
            if (s == 32) check("sq_s32", 64'(sample_data[11:0]), 64'h000);
            if (s == 16) check("saw_s16", 64'(sample_data[23:12]), 64'h000);
        end
        check("saw_range", 64'(bad_range), 64'd0);

        // Triangle at zero amplitude, then a disabled square, then re-enable from a zero phase.
        c = mk(2'b11, MODE_TRI, MODE_SAW, 24'h080000, 24'h100000, 12'h000, 12'hFFF, 1'b0);
        for (int i = 0; i < 4; i++) run_interval(c, 1'b0, c);
        check("tri_amp0", 64'(sample_data[11:0]), 64'h800);
        c = mk(2'b10, MODE_SQUARE, MODE_SAW, 24'h900000, 24'h100000, 12'hFFF, 12'hFFF, 1'b0);
        for (int i = 0; i < 3; i++) run_interval(c, 1'b0, c);
        check("dis_mid", 64'(sample_data[11:0]), 64'h800);
        c = mk(2'b11, MODE_SQUARE, MODE_SAW, 24'h900000, 24'h100000, 12'hFFF, 12'hFFF, 1'b0);
        run_interval(c, 1'b0, c);
        check("reen_first", 64'(sample_data[11:0]), 64'hFFE);
        run_interval(c, 1'b0, c);
        check("reen_second", 64'(sample_data[11:0]), 64'h000);

        // Overrun: three dropped samples, then saturation.
        RST = 1'b1;
        reset_release();
        run_interval(c, 1'b0, c);
        cb = c;
        cb.busy = 1'b1;
        for (int i = 0; i < 3; i++) run_interval(cb, 1'b0, cb);
        check("ovr_three", 64'(overrun_cnt), 64'd3);
        for (int i = 0; i < 300; i++) run_interval(cb, 1'b0, cb);
        check("ovr_sat", 64'(overrun_cnt), 64'd255);
        run_interval(c, 1'b0, c);

        // Pitch change in the middle of an interval.
        c  = mk(2'b11, MODE_SAW, MODE_SQUARE, 24'h010000, 24'h080000, 12'hFFF, 12'hFFF, 1'b0);
        c2 = mk(2'b11, MODE_SAW, MODE_SQUARE, 24'h300000, 24'h080000, 12'hFFF, 12'hFFF, 1'b0);
        run_interval(c, 1'b0, c);
        run_interval(c, 1'b1, c2);
        run_interval(c2, 1'b0, c2);

        // Randomized intervals.
        for (int i = 0; i < 150; i++) begin
            c.en   = 2'($urandom);
            c.mode = 4'($urandom);
            c.step = {24'($urandom), 24'($urandom)};
            c.amp  = {12'($urandom), 12'($urandom)};
            c.busy = ($urandom_range(0, 3) == 0);
            c2      = c;
            c2.step = {24'($urandom), 24'($urandom)};
            c2.amp  = {12'($urandom), 12'($urandom)};
            run_interval(c, ($urandom_range(0, 3) == 0), c2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
